// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings up the board rPLL from the 27 MHz reference.
// Holds the PLL in reset, waits for LOCK, checks that LOCK stays stable, then
// releases the system reset. On lock loss it re-runs the sequence. After a
// bounded number of failed attempts it latches a fault.
// Everything runs in the free-running clkin domain.
//
// Ports:
//   clkin         - free-running reference clock, the only clock
//   reset         - synchronous, active-high
//   pll_lock      - PLL LOCK output, asynchronous to clkin
//   relock_req    - single-cycle restart request; also clears a latched fault
//   pll_reset     - drives the PLL RESET pin
//   sys_reset     - active-high system reset request (low only in RUN)
//   ready         - high only in RUN
//   fault         - high only in FAULT
//   retry_cnt     - failed attempts in the current sequence
//   lost_lock_cnt - saturating count of lock losses seen in RUN
module pll_lock_sequencer #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 64,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lost_lock_cnt
);

    // One counter covers every timed state, so it is sized for the longest one.
    localparam int unsigned MAX_AB   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                       PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_PAR  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                                       MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W    = (MAX_PAR > 1) ? $clog2(MAX_PAR) : 1;
    localparam int unsigned RETRY_W  = 4;
    localparam int unsigned LOST_W   = 8;

    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [LOST_W-1:0]  LOST_SAT  = '1;

    typedef enum logic [2:0] {
        ST_PLLRST   = 3'd0,
        ST_WAITLOCK = 3'd1,
        ST_STABLE   = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lock_sync;
    logic             lock_s;
    logic             enter;
    logic             cnt_run;
    logic             retry_inc;
    logic             retry_clr;
    logic             lost_inc;

    // Two-flop synchroniser for the asynchronous LOCK pin.
    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_sync <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], pll_lock};
        end
    end

    assign lock_s = lock_sync[1];

    // State register plus the shared cycle counter and the two status counters.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state         <= ST_PLLRST;
            cnt           <= '0;
            retry_cnt     <= '0;
            lost_lock_cnt <= '0;
        end else begin
            state <= state_nxt;

            if (enter) begin
                cnt <= '0;
            end else if (cnt_run) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (retry_clr) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
            end

            if (lost_inc && (lost_lock_cnt != LOST_SAT)) begin
                lost_lock_cnt <= lost_lock_cnt + LOST_W'(1);
            end
        end
    end

    // Next-state logic. relock_req outranks every lock/timeout transition and
    // counts as a fresh entry into PLLRST even when already there.
    always_comb begin
        state_nxt = state;
        enter     = 1'b0;
        cnt_run   = 1'b0;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        lost_inc  = 1'b0;

        if (relock_req) begin
            state_nxt = ST_PLLRST;
            enter     = 1'b1;
            retry_clr = 1'b1;
        end else begin
            case (state)
                ST_PLLRST: begin
                    cnt_run = 1'b1;
                    if (cnt == RST_LAST) begin
                        state_nxt = ST_WAITLOCK;
                        enter     = 1'b1;
                    end
                end
                ST_WAITLOCK: begin
                    cnt_run = 1'b1;
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                        enter     = 1'b1;
                    end else if (cnt == TMO_LAST) begin
                        enter = 1'b1;
                        if (retry_cnt == RETRY_MAX) begin
                            state_nxt = ST_FAULT;
                        end else begin
                            state_nxt = ST_PLLRST;
                            retry_inc = 1'b1;
                        end
                    end
                end
                ST_STABLE: begin
                    cnt_run = 1'b1;
                    // A lock drop while qualifying is not a failed attempt;
                    // it just restarts the wait with a fresh timeout.
                    if (!lock_s) begin
                        state_nxt = ST_WAITLOCK;
                        enter     = 1'b1;
                    end else if (cnt == STB_LAST) begin
                        state_nxt = ST_RUN;
                        enter     = 1'b1;
                        retry_clr = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nxt = ST_PLLRST;
                        enter     = 1'b1;
                        lost_inc  = 1'b1;
                    end
                end
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                default: begin
                    state_nxt = ST_PLLRST;
                    enter     = 1'b1;
                end
            endcase
        end
    end

    // Outputs decode straight from the state register, no extra delay.
    always_comb begin
        pll_reset = 1'b0;
        sys_reset = 1'b1;
        ready     = 1'b0;
        fault     = 1'b0;
        case (state)
            ST_PLLRST: begin
                pll_reset = 1'b1;
            end
            ST_RUN: begin
                sys_reset = 1'b0;
                ready     = 1'b1;
            end
            ST_FAULT: begin
                pll_reset = 1'b1;
                fault     = 1'b1;
            end
            default: begin
                pll_reset = 1'b0;
            end
        endcase
    end

endmodule
